osc_bank: RTL and testbench



---
 rtl/osc_bank.sv | 96 +++++++++
 tb/tb_osc_bank.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/osc_bank.sv
// osc_bank: polyphonic MIDI-note pulse oscillators with a shared two-cycle configuration port
// and a registered count of voices currently high.
module osc_bank #(
    parameter int NUM_VOICES = 4,
    parameter int CNT_BW     = 16,
    parameter int F_CLK_HZ   = 1_000_000,
    localparam int VW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1,
    localparam int MW = $clog2(NUM_VOICES + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sync_i,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    input  logic [VW-1:0]         cfg_voice_i,
    input  logic [7:0]            cfg_note_i,
    input  logic [1:0]            cfg_mode_i,
    input  logic                  cfg_gate_i,
    output logic [NUM_VOICES-1:0] wave_o,
    output logic [MW-1:0]         mix_o
);
    localparam longint FB = longint'(F_CLK_HZ) * 500;
    // Half periods of the lowest octave (notes 0..11), shifted down per octave.
    localparam logic [31:0] HALF0 [12] = '{
        32'(FB / 8176),  32'(FB / 8662),  32'(FB / 9177),  32'(FB / 9723),
        32'(FB / 10301), 32'(FB / 10913), 32'(FB / 11562), 32'(FB / 12250),
        32'(FB / 12978), 32'(FB / 13750), 32'(FB / 14568), 32'(FB / 15434)
    };
    localparam logic [31:0] HMAX = 32'(2 ** (CNT_BW - 1) - 1);

    function automatic logic [2*CNT_BW-1:0] convert(input logic [7:0] note, input logic [1:0] mode);
        logic [7:0]  n;
        logic [31:0] h;
        logic [31:0] t;
        n = note < 8'd21 ? 8'd21 : note > 8'd127 ? 8'd127 : note;
        h = HALF0[4'(n % 8'd12)] >> (n / 8'd12);
        h = h == 32'd0 ? 32'd1 : h > HMAX ? HMAX : h;
        t = mode == 2'd0 ? h : mode == 2'd1 ? h >> 1 : mode == 2'd2 ? h >> 2 : h + (h >> 1);
        return {CNT_BW'(h << 1), CNT_BW'(t)};
    endfunction

    localparam logic [2*CNT_BW-1:0] RST_PT = convert(8'd21, 2'd0);

    logic                  accept;
    logic                  pend;
    logic [VW-1:0]         st_voice;
    logic [7:0]            st_note;
    logic [1:0]            st_mode;
    logic                  st_gate;
    logic [CNT_BW-1:0]     cv_p;
    logic [CNT_BW-1:0]     cv_t;
    logic [NUM_VOICES-1:0] gate;
    logic [CNT_BW-1:0]     period [NUM_VOICES];
    logic [CNT_BW-1:0]     thr    [NUM_VOICES];
    logic [CNT_BW-1:0]     phase  [NUM_VOICES];

    assign accept = cfg_valid_i & cfg_ready_o;
    assign {cv_p, cv_t} = convert(st_note, st_mode);

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_wave
        assign wave_o[v] = gate[v] & (phase[v] < thr[v]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_ready_o <= 1'b0;
            pend        <= 1'b0;
            st_voice    <= '0;
            st_note     <= '0;
            st_mode     <= '0;
            st_gate     <= 1'b0;
            mix_o       <= '0;
            gate        <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase[v]  <= '0;
                period[v] <= RST_PT[2*CNT_BW-1:CNT_BW];
                thr[v]    <= RST_PT[CNT_BW-1:0];
            end
        end else begin
            cfg_ready_o <= !accept;
            pend        <= accept;
            if (accept) {st_voice, st_note, st_mode, st_gate} <= {cfg_voice_i, cfg_note_i, cfg_mode_i, cfg_gate_i};
            mix_o <= MW'($countones(wave_o));
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (pend && int'(st_voice) == v) begin
                    gate[v]   <= st_gate;
                    period[v] <= cv_p;
                    thr[v]    <= cv_t;
                    phase[v]  <= '0;
                end else begin
                    phase[v] <= (sync_i || !gate[v] || phase[v] == period[v] - 1'b1) ? '0 : phase[v] + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_osc_bank.sv
// tb_osc_bank: directed stimulus on a 4-voice and a 3-voice build sharing one config bus,
// checked every cycle against a phase-by-elapsed-time model plus literal run-length checks.
module tb_osc_bank;
    localparam int NV = 4;
    localparam int BW = 16;
    localparam int F  = 1_000_000;

    logic       clk = 0, rst = 1, sync = 0, valid = 0, gate_in = 0;
    logic [1:0] voice = 0, mode = 0;
    logic [7:0] note = 0;
    logic       ready4, ready3;
    logic [3:0] wave4;
    logic [2:0] wave3;
    logic [2:0] mix4;
    logic [1:0] mix3;

    osc_bank dut4 (
        .clk_i(clk), .rst_i(rst), .sync_i(sync), .cfg_valid_i(valid), .cfg_ready_o(ready4),
        .cfg_voice_i(voice), .cfg_note_i(note), .cfg_mode_i(mode), .cfg_gate_i(gate_in),
        .wave_o(wave4), .mix_o(mix4)
    );
    osc_bank #(.NUM_VOICES(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .sync_i(sync), .cfg_valid_i(valid), .cfg_ready_o(ready3),
        .cfg_voice_i(voice), .cfg_note_i(note), .cfg_mode_i(mode), .cfg_gate_i(gate_in),
        .wave_o(wave3), .mix_o(mix3)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Model: each voice remembers the edge at which its phase was last zeroed.
    longint     e = 0;
    bit         m_gate [NV];
    int         m_p [NV], m_t [NV];
    longint     m_start [NV];
    bit         m_pend = 0, m_ready = 0, pg;
    int         pv, pn, pm;
    logic [3:0] exp_wave, last_wave = 0;
    int         exp_mix4 = 0, exp_mix3 = 0;

    function automatic int half_of(int n);
        int fm [12] = '{8176, 8662, 9177, 9723, 10301, 10913, 11562, 12250, 12978, 13750, 14568, 15434};
        int nn, h;
        nn = n < 21 ? 21 : (n > 127 ? 127 : n);
        h = ((F * 500) / fm[nn % 12]) >> (nn / 12);
        if (h < 1) h = 1;
        if (h > 2 ** (BW - 1) - 1) h = 2 ** (BW - 1) - 1;
        return h;
    endfunction

    function automatic int thr_of(int h, int m);
        case (m)
            0: return h;
            1: return h / 2;
            2: return h / 4;
            default: return h + h / 2;
        endcase
    endfunction

    always @(posedge clk) begin
        e++;
        exp_mix4 = rst ? 0 : $countones(last_wave);
        exp_mix3 = rst ? 0 : $countones(last_wave[2:0]);
        if (rst) begin
            for (int v = 0; v < NV; v++) begin
                m_gate[v] = 0;
                m_p[v] = 2 * half_of(21);
                m_t[v] = half_of(21);
                m_start[v] = e;
            end
            m_pend = 0;
            m_ready = 0;
        end else begin
            if (m_pend) begin
                m_gate[pv] = pg;
                m_p[pv] = 2 * half_of(pn);
                m_t[pv] = thr_of(half_of(pn), pm);
                m_start[pv] = e;
            end
            if (sync) for (int v = 0; v < NV; v++) m_start[v] = e;
            m_pend = valid && m_ready;
            if (m_pend) begin
                pv = int'(voice);
                pn = int'(note);
                pm = int'(mode);
                pg = gate_in;
            end
            m_ready = !m_pend;
        end
    end

    always @(negedge clk) begin
        for (int v = 0; v < NV; v++)
            exp_wave[v] = m_gate[v] && (((e - m_start[v]) % longint'(m_p[v])) < longint'(m_t[v]));
        last_wave = exp_wave;
        checks++;
        if ({ready4, wave4, mix4} !== {m_ready, exp_wave, 3'(exp_mix4)}) begin
            errors++;
            $display("FAIL model4 edge %0d: ready/wave/mix got %b/%b/%0d want %b/%b/%0d",
                     e, ready4, wave4, mix4, m_ready, exp_wave, exp_mix4);
        end
        checks++;
        if ({ready3, wave3, mix3} !== {m_ready, exp_wave[2:0], 2'(exp_mix3)}) begin
            errors++;
            $display("FAIL model3 edge %0d: ready/wave/mix got %b/%b/%0d want %b/%b/%0d",
                     e, ready3, wave3, mix3, m_ready, exp_wave[2:0], exp_mix3);
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic send(input int v, input int n, input int m, input bit g, input bit keep);
        int w;
        voice = 2'(v);
        note = 8'(n);
        mode = 2'(m);
        gate_in = g;
        valid = 1;
        w = 0;
        while (!ready4 && w < 10) begin
            w++;
            @(negedge clk);
        end
        check("send_ready", int'(ready4), 1);
        @(negedge clk);
        if (!keep) valid = 0;
    endtask

    function automatic int observe(int sel);
        return sel < NV ? int'(wave4[sel]) : int'(mix4);
    endfunction

    task automatic run_len(input int sel, input int val, output int n);
        n = 0;
        while (observe(sel) == val && n < 40000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic send_and_measure(input string name, input int n, input int m, input int hi, input int lo);
        int r;
        send(0, n, m, 1, 0);
        @(negedge clk);
        run_len(0, 1, r);
        check({name, "_high"}, r, hi);
        if (lo > 0) begin
            run_len(0, 0, r);
            check({name, "_low"}, r, lo);
        end
    endtask

    task automatic sync_pulse();
        sync = 1;
        @(negedge clk);
        sync = 0;
        @(negedge clk);
    endtask

    initial begin
        int r;
        longint t0;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("rst_ready", int'(ready4), 1);
        check("rst_wave", int'(wave4), 0);
        check("rst_mix", int'(mix4), 0);

        send_and_measure("a4_m0", 69, 0, 1136, 1136);
        run_len(0, 1, r);
        check("a4_m0_high2", r, 1136);
        send_and_measure("a4_m1", 69, 1, 568, 1704);
        send_and_measure("a4_m2", 69, 2, 284, 1988);
        send_and_measure("a4_m3", 69, 3, 1704, 568);
        send_and_measure("n127", 127, 0, 39, 39);
        send_and_measure("n200", 200, 0, 39, 39);
        send_and_measure("n10", 10, 0, 18181, 0);

        t0 = e;
        for (int i = 0; i < 4; i++) send(i, 69, i, 1, i < 3);
        check("b2b_edges", int'(e - t0), 7);
        @(negedge clk);
        check("v3_loaded", int'(wave4[3]), 1);

        for (int i = 0; i < 4; i++) send(i, 69, 0, i < 3, 0);
        sync_pulse();
        run_len(4, 3, r);
        check("mix3_run", r, 1136);
        run_len(4, 0, r);
        check("mix0_run", r, 1136);
        send(1, 69, 0, 0, 0);
        sync_pulse();
        run_len(4, 2, r);
        check("mix2_run", r, 1136);

        send(2, 69, 0, 1, 0);
        rst = 1;
        sync = 1;
        @(negedge clk);
        check("midrst_ready", int'(ready4), 0);
        check("midrst_wave", int'(wave4), 0);
        check("midrst_mix", int'(mix4), 0);
        rst = 0;
        sync = 0;
        @(negedge clk);
        check("post_rst_ready", int'(ready4), 1);
        repeat (5) @(negedge clk);
        check("post_rst_wave", int'(wave4), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
